// File: rtl/raizing_pcm_bankarb.sv
// PCM bank mapper and round-robin ROM port arbiter for up to four M6295 voices.
// Each voice has a one-byte cache; misses are fetched one at a time over ROM_CS/ROM_OK.
module raizing_pcm_bankarb #(
  parameter int unsigned       CHIPS     = 2,
  parameter int unsigned       REQ_AW    = 18,
  parameter int unsigned       ROM_AW    = 21,
  parameter logic [ROM_AW-1:0] CHIP_OFFS = 21'h100000,
  parameter logic [CHIPS-1:0]  PAGED     = '0
) (
  input  logic                    CLK96,
  input  logic                    RESET96_N,
  input  logic                    BANK_WR,
  input  logic [1:0]              BANK_CHIP,
  input  logic [1:0]              BANK_IDX,
  input  logic [7:0]              BANK_DATA,
  input  logic [CHIPS*REQ_AW-1:0] REQ_ADDR,
  output logic [CHIPS*8-1:0]      REQ_DATA,
  output logic [CHIPS-1:0]        REQ_OK,
  output logic                    ROM_CS,
  output logic [ROM_AW-1:0]       ROM_ADDR,
  input  logic [7:0]              ROM_DOUT,
  input  logic                    ROM_OK
);

  localparam int unsigned CW = (CHIPS > 1) ? $clog2(CHIPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        bank_q [CHIPS][4];
  logic [7:0]        bank_d [CHIPS][4];
  logic [ROM_AW-1:0] tag_q  [CHIPS];
  logic [ROM_AW-1:0] tag_d  [CHIPS];
  logic [7:0]        data_q [CHIPS];
  logic [7:0]        data_d [CHIPS];
  logic [CHIPS-1:0]  valid_q, valid_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     grant_q, grant_d;
  logic              rom_cs_q, rom_cs_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;

  logic [ROM_AW-1:0] trans [CHIPS];
  logic [CHIPS-1:0]  hit;
  logic [CW-1:0]     pick_lo, pick_hi;
  logic              found_lo, found_hi;

  // Per-chip translation and cache hit; phrase-table page for low addresses when paged.
  for (genvar c = 0; c < CHIPS; c++) begin : g_chip
    localparam logic [ROM_AW-1:0] BASE = ROM_AW'(CHIP_OFFS * c);
    logic [REQ_AW-1:0] addr;
    logic [1:0]        slot;

    assign addr  = REQ_ADDR[c*REQ_AW +: REQ_AW];
    assign slot  = (PAGED[c] && (addr < REQ_AW'(32'h400))) ? addr[9:8] : addr[17:16];
    assign trans[c] = BASE + ROM_AW'({bank_q[c][slot], addr[15:0]});
    assign hit[c]   = valid_q[c] && (tag_q[c] == trans[c]);
    assign REQ_OK[c] = hit[c];
    assign REQ_DATA[c*8 +: 8] = data_q[c];
  end

  // Rotating priority: lowest missing chip at or above rr, else lowest missing chip.
  always_comb begin
    pick_lo  = '0;
    pick_hi  = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int c = int'(CHIPS) - 1; c >= 0; c--) begin
      if (!hit[c]) begin
        pick_lo  = CW'(c);
        found_lo = 1'b1;
        if (c >= int'(rr_q)) begin
          pick_hi  = CW'(c);
          found_hi = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;

    for (int c = 0; c < int'(CHIPS); c++) begin
      if (BANK_WR && (BANK_CHIP == 2'(c))) bank_d[c][BANK_IDX] = BANK_DATA;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (found_lo) begin
          grant_d = found_hi ? pick_hi : pick_lo;
          for (int c = 0; c < int'(CHIPS); c++) begin
            if (grant_d == CW'(c)) rom_addr_d = trans[c];
          end
          rom_cs_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      // ROM_OK here may still belong to the previous address, so it is ignored.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ROM_OK) begin
          for (int c = 0; c < int'(CHIPS); c++) begin
            if (grant_q == CW'(c)) begin
              tag_d[c]   = rom_addr_q;
              data_d[c]  = ROM_DOUT;
              valid_d[c] = 1'b1;
            end
          end
          rr_d     = (int'(grant_q) == int'(CHIPS) - 1) ? '0 : CW'(grant_q + 1'b1);
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      for (int c = 0; c < int'(CHIPS); c++) begin
        tag_q[c]  <= '0;
        data_q[c] <= '0;
        for (int s = 0; s < 4; s++) bank_q[c][s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      bank_q     <= bank_d;
    end
  end

  assign ROM_CS   = rom_cs_q;
  assign ROM_ADDR = rom_addr_q;

endmodule

// File: tb/tb_raizing_pcm_bankarb.sv
// Bench for raizing_pcm_bankarb: directed scenarios plus random traffic against a
// translation/ROM reference model built from the bank-table rules.
module tb_raizing_pcm_bankarb;

  localparam int unsigned CHIPS  = 2;
  localparam int unsigned REQ_AW = 18;
  localparam int unsigned ROM_AW = 21;
  localparam logic [1:0]  PAGED_CFG = 2'b01;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    BANK_WR;
  logic [1:0]              BANK_CHIP;
  logic [1:0]              BANK_IDX;
  logic [7:0]              BANK_DATA;
  logic [CHIPS*REQ_AW-1:0] REQ_ADDR;
  logic [CHIPS*8-1:0]      REQ_DATA;
  logic [CHIPS-1:0]        REQ_OK;
  logic                    ROM_CS;
  logic [ROM_AW-1:0]       ROM_ADDR;
  logic [7:0]              ROM_DOUT;
  logic                    ROM_OK;

  raizing_pcm_bankarb #(
    .CHIPS(CHIPS), .REQ_AW(REQ_AW), .ROM_AW(ROM_AW),
    .CHIP_OFFS(21'h100000), .PAGED(PAGED_CFG)
  ) dut (
    .CLK96(clk), .RESET96_N(rst_n),
    .BANK_WR(BANK_WR), .BANK_CHIP(BANK_CHIP), .BANK_IDX(BANK_IDX), .BANK_DATA(BANK_DATA),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_OK(REQ_OK),
    .ROM_CS(ROM_CS), .ROM_ADDR(ROM_ADDR), .ROM_DOUT(ROM_DOUT), .ROM_OK(ROM_OK)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int rom_delay = 0;
  int rom_cnt   = 0;
  logic [7:0]  m_bank [CHIPS][4];
  logic [17:0] m_addr [CHIPS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_byte(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
  endfunction

  function automatic logic [20:0] xlate(input int c, input logic [17:0] a);
    logic [1:0]  s;
    logic [23:0] raw;
    s   = (PAGED_CFG[c] && (a < 18'h400)) ? a[9:8] : a[17:16];
    raw = {m_bank[c][s], a[15:0]};
    return 21'(21'(c) * 21'h100000 + 21'(raw));
  endfunction

  function automatic logic [7:0] req_byte(input int c);
    return REQ_DATA[c*8 +: 8];
  endfunction

  task automatic clear_model();
    for (int c = 0; c < int'(CHIPS); c++)
      for (int s = 0; s < 4; s++) m_bank[c][s] = 8'h00;
  endtask

  task automatic set_addr(input int c, input logic [17:0] a);
    REQ_ADDR[c*REQ_AW +: REQ_AW] = a;
    m_addr[c] = a;
  endtask

  task automatic bank_write(input int c, input int i, input logic [7:0] d);
    @(negedge clk);
    BANK_WR = 1'b1; BANK_CHIP = 2'(c); BANK_IDX = 2'(i); BANK_DATA = d;
    @(negedge clk);
    BANK_WR = 1'b0;
    if (c < int'(CHIPS)) m_bank[c][i] = d;
  endtask

  task automatic wait_grant(input string tag, output logic [20:0] addr);
    logic prev;
    bit   seen;
    seen = 1'b0;
    prev = ROM_CS;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (ROM_CS && !prev) seen = 1'b1;
      else prev = ROM_CS;
    end
    addr = ROM_ADDR;
    chk({tag, " grant seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = !ROM_CS;
    end
    chk({tag, " fetch done"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_ok(input string tag, input int c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = REQ_OK[c];
    end
    chk({tag, " ok"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_all_ok(input string tag, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(posedge clk); #1;
      seen = &REQ_OK;
    end
    chk({tag, " all ok"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_data(input string tag);
    for (int c = 0; c < int'(CHIPS); c++)
      chk($sformatf("%s data%0d", tag, c), 32'(req_byte(c)), 32'(rom_byte(xlate(c, m_addr[c]))));
  endtask

  // ROM model: data follows the address; OK either tied high or after rom_delay cycles of CS.
  initial begin
    ROM_OK = 1'b0;
    ROM_DOUT = 8'h00;
    forever begin
      @(negedge clk);
      if (ROM_CS) rom_cnt++;
      else rom_cnt = 0;
      ROM_OK   = (rom_delay == 0) || (rom_cnt > rom_delay);
      ROM_DOUT = rom_byte(ROM_ADDR);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] a;
    BANK_WR = 1'b0; BANK_CHIP = 2'd0; BANK_IDX = 2'd0; BANK_DATA = 8'h00;
    REQ_ADDR = '0;
    for (int c = 0; c < int'(CHIPS); c++) m_addr[c] = 18'h0;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    chk("reset rom_cs", 32'(ROM_CS), 32'd0);
    chk("reset rom_addr", 32'(ROM_ADDR), 32'd0);
    chk("reset req_ok", 32'(REQ_OK), 32'd0);
    chk("reset req_data", 32'(REQ_DATA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_all_ok("settle", 100);
    chk_data("settle");

    // Single miss with ROM_OK tied high: 3-edge latency, CS high for 2 cycles.
    @(negedge clk);
    set_addr(0, 18'h01234);
    #1 chk("t1 comb miss", 32'(REQ_OK[0]), 32'd0);
    @(posedge clk); #1;
    chk("t1 cs e1", 32'(ROM_CS), 32'd1);
    chk("t1 rom_addr", 32'(ROM_ADDR), 32'h001234);
    chk("t1 ok e1", 32'(REQ_OK[0]), 32'd0);
    @(posedge clk); #1;
    chk("t1 cs e2", 32'(ROM_CS), 32'd1);
    chk("t1 ok e2", 32'(REQ_OK[0]), 32'd0);
    @(posedge clk); #1;
    chk("t1 cs e3", 32'(ROM_CS), 32'd0);
    chk("t1 ok e3", 32'(REQ_OK[0]), 32'd1);
    chk("t1 data", 32'(req_byte(0)), 32'(rom_byte(21'h001234)));
    chk("t1 chip1 ok", 32'(REQ_OK[1]), 32'd1);

    // Bank write on chip1, then slot-selective invalidation.
    bank_write(1, 2, 8'h05);
    set_addr(1, 18'h2ABCD);
    wait_grant("t2", a);
    chk("t2 rom_addr", 32'(a), 32'h15ABCD);
    wait_ok("t2", 1);
    chk_data("t2");
    bank_write(1, 3, 8'hA5);
    chk("t2 other slot keeps hit", 32'(REQ_OK), 32'h3);
    bank_write(2, 0, 8'hFF);
    chk("t2 chip2 write ignored", 32'(REQ_OK), 32'h3);
    bank_write(1, 2, 8'h06);
    chk("t2 slot change miss", 32'(REQ_OK), 32'h1);
    wait_ok("t2b", 1);
    chk("t2b data", 32'(req_byte(1)), 32'(rom_byte(21'h16ABCD)));

    // Paging on chip0 only; simultaneous misses with rr = 0.
    bank_write(0, 3, 8'h07);
    set_addr(0, 18'h00310);
    set_addr(1, 18'h00310);
    wait_grant("t3 first", a);
    chk("t3 first addr", 32'(a), 32'h070310);
    wait_grant("t3 second", a);
    chk("t3 second addr", 32'(a), 32'h100310);
    wait_all_ok("t3", 50);
    chk_data("t3");

    // Paging boundary and simultaneous misses with rr = 1.
    @(negedge clk);
    set_addr(0, 18'h003FF);
    wait_grant("t3b", a);
    chk("t3b paged edge", 32'(a), 32'h0703FF);
    wait_all_ok("t3b", 50);
    @(negedge clk);
    set_addr(0, 18'h00400);
    set_addr(1, 18'h003FF);
    wait_grant("t3c first", a);
    chk("t3c first addr", 32'(a), 32'h1003FF);
    wait_grant("t3c second", a);
    chk("t3c unpaged 0x400", 32'(a), 32'h000400);
    wait_all_ok("t3c", 50);
    chk_data("t3c");

    // Address change while the fetch waits on a slow ROM.
    rom_delay = 10;
    @(negedge clk);
    set_addr(0, 18'h01000);
    wait_grant("t4", a);
    chk("t4 first addr", 32'(a), 32'h001000);
    repeat (3) @(negedge clk);
    set_addr(0, 18'h02000);
    wait_done("t4");
    chk("t4 stale tag no ok", 32'(REQ_OK[0]), 32'd0);
    wait_grant("t4 refetch", a);
    chk("t4 refetch addr", 32'(a), 32'h002000);
    wait_ok("t4", 0);
    chk("t4 data", 32'(req_byte(0)), 32'(rom_byte(21'h002000)));

    // Reset in the middle of WAIT.
    @(negedge clk);
    set_addr(0, 18'h30010);
    wait_grant("t5", a);
    chk("t5 addr", 32'(a), 32'h070010);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("t5 cs drop", 32'(ROM_CS), 32'd0);
    chk("t5 ok clear", 32'(REQ_OK), 32'd0);
    chk("t5 data clear", 32'(REQ_DATA), 32'd0);
    chk("t5 rom_addr clear", 32'(ROM_ADDR), 32'd0);
    @(negedge clk);
    rom_delay = 0;
    rst_n = 1'b1;
    #1 chk("t5 no residual cs", 32'(ROM_CS), 32'd0);
    wait_grant("t5 restart", a);
    chk("t5 restart addr", 32'(a), 32'h000010);
    wait_all_ok("t5", 50);
    chk_data("t5");

    // Random traffic: any hit must carry the byte at the model-translated address.
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      for (int c = 0; c < int'(CHIPS); c++) begin
        if (REQ_OK[c])
          chk($sformatf("rnd hit data c%0d", c), 32'(req_byte(c)),
              32'(rom_byte(xlate(c, m_addr[c]))));
      end
      case ($urandom_range(0, 9))
        0: bank_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      8'($urandom_range(0, 7)));
        1, 2: begin
          if ($urandom_range(0, 1) == 1) set_addr(int'($urandom_range(0, 1)), 18'($urandom_range(0, 'h7FF)));
          else set_addr(int'($urandom_range(0, 1)), 18'($urandom));
        end
        3: rom_delay = int'($urandom_range(0, 3));
        default: ;
      endcase
    end
    wait_all_ok("rnd settle", 200);
    chk_data("rnd settle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
